razor_iter_ctrl: RTL and testbench

Iteration scheduler and Razor error-recovery controller for the fully parallel turbo decoder datapath. It sequences decoding half-iterations and drives the odd/even section phase, the register-update enable and the state-clear strobe shared by all alpha/beta recursion sections. It collects the per-section Razor error flags and, on any timing error, stalls the datapath for one replay cycle. It also counts errors and aborts the decode when replays persist.

---
 rtl/razor_iter_ctrl_if.sv | 30 +++
 rtl/razor_iter_ctrl.sv | 178 +++++++++++++++++
 tb/tb_razor_iter_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/razor_iter_ctrl_if.sv
// Handshake bundle between the turbo-decoder sequencer and razor_iter_ctrl:
// decode request/abort, section error flags, and datapath control/status.
interface razor_iter_ctrl_if #(
    parameter int NSEC = 8,
    parameter int ITW  = 5,
    parameter int ECW  = 8
);
    logic            start;
    logic            abort;
    logic [ITW-1:0]  num_iter;
    logic [NSEC-1:0] Error_in;
    logic            clear_state;
    logic            update_en;
    logic            phase;
    logic            busy;
    logic            done;
    logic            fail;
    logic [ECW-1:0]  err_cnt;
    logic [ITW:0]    hcnt;

    modport master (
        output start, abort, num_iter, Error_in,
        input  clear_state, update_en, phase, busy, done, fail, err_cnt, hcnt
    );

    modport slave (
        input  start, abort, num_iter, Error_in,
        output clear_state, update_en, phase, busy, done, fail, err_cnt, hcnt
    );
endinterface

// File: rtl/razor_iter_ctrl.sv
// Half-iteration scheduler for the parallel turbo decoder with Razor replay:
// a timing error stalls the datapath for one cycle, persistent errors abort.
module razor_iter_ctrl #(
    parameter int NSEC      = 8,
    parameter int ITW       = 5,
    parameter int ECW       = 8,
    parameter int MAXREPLAY = 3
) (
    input  logic            Clock,
    input  logic            nReset,
    razor_iter_ctrl_if.slave bus
);

    localparam int RCW = $clog2(MAXREPLAY + 1);
    localparam logic [RCW-1:0] MAXREPLAY_C = RCW'(MAXREPLAY);
    localparam logic [ITW-1:0] ONE_ITER    = ITW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPLAY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t         state_r;
    logic [ITW-1:0] n_r;
    logic [ITW:0]   hcnt_r;
    logic [ECW-1:0] err_cnt_r;
    logic [RCW-1:0] rc_r;
    logic           fail_r;
    logic           clear_state_r;
    logic           update_en_r;
    logic           phase_r;
    logic           busy_r;
    logic           done_r;

    logic           err_any_s;
    logic [ITW-1:0] n_req_s;
    logic [ITW:0]   hcnt_inc_s;
    logic [ITW:0]   two_n_s;
    logic [RCW-1:0] rc_inc_s;

    function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
        logic [ECW-1:0] r;
        if (v == {ECW{1'b1}}) begin
            r = v;
        end else begin
            r = v + ECW'(1);
        end
        return r;
    endfunction

    assign err_any_s  = |bus.Error_in;
    assign n_req_s    = (bus.num_iter == {ITW{1'b0}}) ? ONE_ITER : bus.num_iter;
    assign hcnt_inc_s = hcnt_r + (ITW+1)'(1);
    assign two_n_s    = {n_r, 1'b0};
    assign rc_inc_s   = rc_r + RCW'(1);

    // Sequencer FSM; every output is registered alongside the next state.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r       <= ST_IDLE;
            n_r           <= {ITW{1'b0}};
            hcnt_r        <= {(ITW+1){1'b0}};
            err_cnt_r     <= {ECW{1'b0}};
            rc_r          <= {RCW{1'b0}};
            fail_r        <= 1'b0;
            clear_state_r <= 1'b0;
            update_en_r   <= 1'b0;
            phase_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else if (bus.abort) begin
            // counters and fail flag hold so software can inspect them
            state_r       <= ST_IDLE;
            clear_state_r <= 1'b0;
            update_en_r   <= 1'b0;
            phase_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    update_en_r <= 1'b0;
                    phase_r     <= 1'b0;
                    done_r      <= 1'b0;
                    if (bus.start) begin
                        state_r       <= ST_INIT;
                        n_r           <= n_req_s;
                        hcnt_r        <= {(ITW+1){1'b0}};
                        err_cnt_r     <= {ECW{1'b0}};
                        rc_r          <= {RCW{1'b0}};
                        fail_r        <= 1'b0;
                        clear_state_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                        clear_state_r <= 1'b0;
                        busy_r        <= 1'b0;
                    end
                end
                ST_INIT: begin
                    state_r       <= ST_RUN;
                    clear_state_r <= 1'b0;
                    update_en_r   <= 1'b1;
                    phase_r       <= 1'b0;
                    busy_r        <= 1'b1;
                    done_r        <= 1'b0;
                end
                ST_RUN: begin
                    clear_state_r <= 1'b0;
                    busy_r        <= 1'b1;
                    if (err_any_s) begin
                        // the committed update is suspect: hold hcnt/phase and replay
                        err_cnt_r   <= sat_inc(err_cnt_r);
                        rc_r        <= rc_inc_s;
                        update_en_r <= 1'b0;
                        if (rc_inc_s == MAXREPLAY_C) begin
                            state_r <= ST_DONE;
                            fail_r  <= 1'b1;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_REPLAY;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        hcnt_r  <= hcnt_inc_s;
                        phase_r <= ~phase_r;
                        rc_r    <= {RCW{1'b0}};
                        if (hcnt_inc_s == two_n_s) begin
                            state_r     <= ST_DONE;
                            update_en_r <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            state_r     <= ST_RUN;
                            update_en_r <= 1'b1;
                            done_r      <= 1'b0;
                        end
                    end
                end
                ST_REPLAY: begin
                    state_r       <= ST_RUN;
                    clear_state_r <= 1'b0;
                    update_en_r   <= 1'b1;
                    busy_r        <= 1'b1;
                    done_r        <= 1'b0;
                end
                ST_DONE: begin
                    state_r       <= ST_IDLE;
                    clear_state_r <= 1'b0;
                    update_en_r   <= 1'b0;
                    phase_r       <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    clear_state_r <= 1'b0;
                    update_en_r   <= 1'b0;
                    phase_r       <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clear_state = clear_state_r;
    assign bus.update_en   = update_en_r;
    assign bus.phase       = phase_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.fail        = fail_r;
    assign bus.err_cnt     = err_cnt_r;
    assign bus.hcnt        = hcnt_r;

endmodule

// File: tb/tb_razor_iter_ctrl.sv
// Bench for razor_iter_ctrl: directed vector table, hand-written corner
// sequences, and random stimulus against a cycle-level reference model.
module tb_razor_iter_ctrl;
    localparam int NSEC = 8;
    localparam int ITW  = 5;
    localparam int ECW  = 8;
    localparam int MAXREPLAY = 3;

    logic Clock  = 1'b0;
    logic nReset = 1'b1;
    always #5 Clock = ~Clock;

    razor_iter_ctrl_if #(.NSEC(NSEC), .ITW(ITW), .ECW(ECW)) bus ();
    razor_iter_ctrl_if #(.NSEC(NSEC), .ITW(ITW), .ECW(2))   bus2 ();

    razor_iter_ctrl #(.NSEC(NSEC), .ITW(ITW), .ECW(ECW), .MAXREPLAY(MAXREPLAY)) dut (
        .Clock(Clock), .nReset(nReset), .bus(bus)
    );
    razor_iter_ctrl #(.NSEC(NSEC), .ITW(ITW), .ECW(2), .MAXREPLAY(MAXREPLAY)) dut_s (
        .Clock(Clock), .nReset(nReset), .bus(bus2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int ctx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ctx=%0d: got %0h expected %0h", name, ctx, act, exp);
        end
    endtask

    typedef struct {
        logic [ITW-1:0]  n;
        logic [NSEC-1:0] err_val;
        logic [31:0]     err_m;
        int              abort_c;
        int              hold_c;
        logic [31:0]     clr_m, upd_m, ph_m, busy_m, done_m;
        int              hc, ec;
        logic            fl;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input logic [ITW-1:0] n, input logic [NSEC-1:0] ev,
                           input logic [31:0] em, input int ac, input int hcyc,
                           input logic [31:0] clr, input logic [31:0] upd, input logic [31:0] ph,
                           input logic [31:0] bsy, input logic [31:0] dn,
                           input int hc, input int ec, input logic fl);
        vecs[i].n = n;         vecs[i].err_val = ev; vecs[i].err_m = em;
        vecs[i].abort_c = ac;  vecs[i].hold_c = hcyc;
        vecs[i].clr_m = clr;   vecs[i].upd_m = upd;  vecs[i].ph_m = ph;
        vecs[i].busy_m = bsy;  vecs[i].done_m = dn;
        vecs[i].hc = hc;       vecs[i].ec = ec;      vecs[i].fl = fl;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_iter = 5'd0; bus.Error_in = 8'h00;
    endtask

    // reference model: operation kind of the current cycle plus decode bookkeeping
    localparam int K_IDLE = 0, K_INIT = 1, K_RUN = 2, K_REPLAY = 3, K_DONE = 4;
    int   mk, mN, mhc, mec, mrc;
    logic mfl;

    task automatic model_reset();
        mk = K_IDLE; mN = 0; mhc = 0; mec = 0; mrc = 0; mfl = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic ab, input int ni, input logic [NSEC-1:0] ev);
        if (ab) begin
            mk = K_IDLE;
        end else begin
            case (mk)
                K_IDLE: if (st) begin
                    mN = (ni == 0) ? 1 : ni;
                    mhc = 0; mec = 0; mrc = 0; mfl = 1'b0;
                    mk = K_INIT;
                end
                K_INIT:   mk = K_RUN;
                K_REPLAY: mk = K_RUN;
                K_DONE:   mk = K_IDLE;
                K_RUN: if (ev != 0) begin
                    if (mec < 255) mec++;
                    mrc++;
                    if (mrc == MAXREPLAY) begin mfl = 1'b1; mk = K_DONE; end
                    else mk = K_REPLAY;
                end else begin
                    mhc++;
                    mrc = 0;
                    if (mhc == 2 * mN) mk = K_DONE;
                end
                default: mk = K_IDLE;
            endcase
        end
    endtask

    task automatic model_compare(input int c);
        check("rnd_clear_state", c, 32'(bus.clear_state), 32'(mk == K_INIT));
        check("rnd_update_en",   c, 32'(bus.update_en),   32'(mk == K_RUN));
        check("rnd_busy",        c, 32'(bus.busy),        32'(mk != K_IDLE));
        check("rnd_done",        c, 32'(bus.done),        32'(mk == K_DONE));
        check("rnd_fail",        c, 32'(bus.fail),        32'(mfl));
        check("rnd_err_cnt",     c, 32'(bus.err_cnt),     32'(mec));
        check("rnd_hcnt",        c, 32'(bus.hcnt),        32'(mhc));
        if (mk == K_RUN || mk == K_REPLAY)
            check("rnd_phase", c, 32'(bus.phase), 32'(mhc % 2));
        else if (mk != K_DONE)
            check("rnd_phase", c, 32'(bus.phase), 32'd0);
    endtask

    initial begin
        int nerr;
        idle_inputs();
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.num_iter = 5'd0; bus2.Error_in = 8'h00;

        // asynchronous reset: outputs must be zero before any clock edge
        #2 nReset = 1'b0;
        #2;
        check("rst_clear_state", 0, 32'(bus.clear_state), 32'd0);
        check("rst_update_en",   0, 32'(bus.update_en),   32'd0);
        check("rst_phase",       0, 32'(bus.phase),       32'd0);
        check("rst_busy",        0, 32'(bus.busy),        32'd0);
        check("rst_done",        0, 32'(bus.done),        32'd0);
        check("rst_fail",        0, 32'(bus.fail),        32'd0);
        check("rst_err_cnt",     0, 32'(bus.err_cnt),     32'd0);
        check("rst_hcnt",        0, 32'(bus.hcnt),        32'd0);
        tick();
        nReset = 1'b1;
        tick();

        // n, err value, err cycles, abort cyc, start-hold cyc, clear, update, phase, busy, done, hcnt, err_cnt, fail
        set_vec(0, 5'd2, 8'h00, 32'h0,        -1, 0, 32'h2, 32'h3C, 32'h28, 32'h7E, 32'h40, 4, 0, 1'b0);
        set_vec(1, 5'd1, 8'h08, 32'h4,        -1, 0, 32'h2, 32'h34, 32'h20, 32'h7E, 32'h40, 2, 1, 1'b0);
        set_vec(2, 5'd4, 8'hFF, 32'hFFFFFFFE, -1, 0, 32'h2, 32'h54, 32'h00, 32'hFE, 32'h80, 0, 3, 1'b1);
        set_vec(3, 5'd3, 8'h00, 32'h0,         3, 0, 32'h2, 32'h0C, 32'h08, 32'h0E, 32'h00, 1, 0, 1'b0);
        set_vec(4, 5'd0, 8'h00, 32'h0,        -1, 0, 32'h2, 32'h0C, 32'h08, 32'h1E, 32'h10, 2, 0, 1'b0);
        set_vec(5, 5'd1, 8'h40, 32'h8,        -1, 0, 32'h2, 32'h2C, 32'h38, 32'h7E, 32'h40, 2, 1, 1'b0);
        set_vec(6, 5'd2, 8'h00, 32'h0,        -1, 6, 32'h2, 32'h3C, 32'h28, 32'h7E, 32'h40, 4, 0, 1'b0);

        for (int v = 0; v < 7; v++) begin
            bus.start = 1'b1;
            bus.num_iter = vecs[v].n;
            tick();
            for (int c = 1; c <= 12; c++) begin
                int ctx;
                ctx = v * 100 + c;
                bus.start    = (c <= vecs[v].hold_c) ? 1'b1 : 1'b0;
                bus.num_iter = 5'd7;
                bus.abort    = (c == vecs[v].abort_c) ? 1'b1 : 1'b0;
                bus.Error_in = vecs[v].err_m[c] ? vecs[v].err_val : 8'h00;
                check("vec_clear_state", ctx, 32'(bus.clear_state), 32'(vecs[v].clr_m[c]));
                check("vec_update_en",   ctx, 32'(bus.update_en),   32'(vecs[v].upd_m[c]));
                check("vec_phase",       ctx, 32'(bus.phase),       32'(vecs[v].ph_m[c]));
                check("vec_busy",        ctx, 32'(bus.busy),        32'(vecs[v].busy_m[c]));
                check("vec_done",        ctx, 32'(bus.done),        32'(vecs[v].done_m[c]));
                tick();
            end
            idle_inputs();
            check("vec_hcnt",    v, 32'(bus.hcnt),    32'(vecs[v].hc));
            check("vec_err_cnt", v, 32'(bus.err_cnt), 32'(vecs[v].ec));
            check("vec_fail",    v, 32'(bus.fail),    32'(vecs[v].fl));
        end

        // reset in the middle of a decode, then num_iter=0 behaves as one iteration
        bus.start = 1'b1; bus.num_iter = 5'd3;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midrst_pre_busy", 0, 32'(bus.update_en), 32'd1);
        #2 nReset = 1'b0;
        #1;
        check("midrst_update_en", 0, 32'(bus.update_en), 32'd0);
        check("midrst_busy",      0, 32'(bus.busy),      32'd0);
        check("midrst_phase",     0, 32'(bus.phase),     32'd0);
        check("midrst_hcnt",      0, 32'(bus.hcnt),      32'd0);
        tick();
        nReset = 1'b1;
        tick();
        check("midrst_no_done", 0, 32'(bus.done), 32'd0);
        bus.start = 1'b1; bus.num_iter = 5'd0;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("n0_done", c, 32'(bus.done), 32'(c == 4));
            tick();
        end
        check("n0_hcnt", 0, 32'(bus.hcnt), 32'd2);

        // ECW=2 instance: alternating errored/clean RUN cycles saturate err_cnt at 3
        bus2.start = 1'b1; bus2.num_iter = 5'd4;
        tick();
        bus2.start = 1'b0;
        nerr = 0;
        for (int c = 1; c <= 30; c++) begin
            logic e;
            e = (c >= 2 && c < 26 && ((c - 2) % 3) == 0);
            bus2.Error_in = e ? 8'h01 : 8'h00;
            check("sat_err_cnt", c, 32'(bus2.err_cnt), 32'((nerr > 3) ? 3 : nerr));
            check("sat_fail",    c, 32'(bus2.fail),    32'd0);
            check("sat_done",    c, 32'(bus2.done),    32'(c == 26));
            if (e) nerr++;
            tick();
        end
        bus2.Error_in = 8'h00;
        check("sat_hcnt", 0, 32'(bus2.hcnt), 32'd8);

        // randomized stimulus against the reference model
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        idle_inputs();
        model_reset();
        tick();
        model_compare(-1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic st, ab;
            logic [ITW-1:0] ni;
            logic [NSEC-1:0] ev;
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 60) == 0);
            ni = ITW'($urandom_range(0, 4));
            ev = ($urandom_range(0, 4) == 0) ? NSEC'($urandom) : 8'h00;
            bus.start = st; bus.abort = ab; bus.num_iter = ni; bus.Error_in = ev;
            tick();
            model_step(st, ab, int'(ni), ev);
            model_compare(cyc);
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
